mdu_seq: RTL and testbench

- Parametrised multi-cycle multiply/divide unit for stage E. It is the next-generation HI/LO engine.
- Replaces behavioural `*`, `/` and `%` with a synthesizable iterative shift-add multiplier and a restoring divider.
- Adds configurable data width and multiplier step size.
- Adds a done pulse and an abort input so the pipeline controller can flush an in-flight operation on exception.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_div_core.sv | 73 +++++++
 rtl/mdu_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_mdu_seq.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the sequential multiply/divide unit.
//   - mdu_op_e    : operation codes presented on mdu_seq.op
//   - mdu_state_e : FSM state encoding of mdu_seq
//   - is_signed_op: true for the ops that work on two's-complement operands
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_OP_NONE  = 4'd0,
        MDU_OP_MULT  = 4'd1,
        MDU_OP_MULTU = 4'd2,
        MDU_OP_DIV   = 4'd3,
        MDU_OP_DIVU  = 4'd4,
        MDU_OP_MTHI  = 4'd5,
        MDU_OP_MTLO  = 4'd6,
        MDU_OP_MADD  = 4'd7,
        MDU_OP_MADDU = 4'd8,
        MDU_OP_MSUB  = 4'd9,
        MDU_OP_MSUBU = 4'd10
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_DIV) ||
               (op == MDU_OP_MADD) || (op == MDU_OP_MSUB);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: unsigned restoring divider, one quotient bit per clock.
//   clk        : clock
//   reset      : synchronous active-high reset
//   i_start    : load operands and begin dividing (ignored if i_abort)
//   i_abort    : stop any division in progress
//   i_dividend : unsigned dividend, latched on i_start
//   i_divisor  : unsigned divisor (non-zero), latched on i_start
//   o_quo      : quotient, valid once the final iteration has completed
//   o_rem      : remainder, valid once the final iteration has completed
//   o_done     : high in the cycle whose clock edge performs the last iteration
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quo,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_done
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic             r_run;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   w_trial;

    // Shift the next dividend bit into the partial remainder and try to
    // subtract the divisor; a borrow (MSB set) means the trial failed.
    // The partial remainder is always below the divisor, so the shifted
    // value fits in WIDTH+1 bits and a successful result fits in WIDTH.
    assign w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
    assign o_done  = r_run && (r_cnt == CW'(WIDTH - 1));
    assign o_quo   = r_quo;
    assign o_rem   = r_rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run <= 1'b0;
            r_cnt <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
        end else if (i_abort) begin
            r_run <= 1'b0;
        end else if (i_start) begin
            r_run <= 1'b1;
            r_cnt <= '0;
            r_quo <= i_dividend;
            r_rem <= '0;
            r_dvs <= i_divisor;
        end else if (r_run) begin
            if (!w_trial[WIDTH]) begin
                r_rem <= w_trial[WIDTH-1:0];
            end else begin
                r_rem <= {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
            end
            // Dividend bits leave at the top while quotient bits enter at the bottom.
            r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle HI/LO multiply/divide unit for the execute stage.
// Iterative shift-add multiplier (MUL_STEP bits per cycle) and restoring
// divider (mdu_div_core), with sign fix-up and HI/LO commit in a FIX cycle.
//
// Build option: define MDU_ACCUM_EN to support MADD/MADDU/MSUB/MSUBU; when it
// is undefined those codes are ignored like any other unknown op.
//
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset (clears HI/LO and all state)
//   start : operation request, sampled only while idle
//   op    : operation code (mdu_pkg::mdu_op_e)
//   srca  : rs operand
//   srcb  : rt operand
//   abort : cancel an in-flight op (no commit) or suppress a start
//   hi/lo : HI and LO registers
//   busy  : unit occupied; also high combinationally in the issue cycle of
//           a multi-cycle op so the controller can stall immediately
//   done  : one-cycle pulse in the cycle after HI/LO commit
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             abort,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int MCW   = $clog2(STEPS) + 1;

    generate
        if ((WIDTH % MUL_STEP) != 0) begin : g_bad_step
            $error("mdu_seq: WIDTH must be a multiple of MUL_STEP");
        end
        if ((WIDTH < 8) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("mdu_seq: WIDTH must be even and at least 8");
        end
    endgenerate

    mdu_state_e         r_state;
    mdu_state_e         w_state_next;
    logic [3:0]         r_op;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [MCW-1:0]     r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_is_long;
    logic               w_accept;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_pp [MUL_STEP];
    logic [2*WIDTH-1:0] w_step_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_div_quo;
    logic [WIDTH-1:0]   w_div_rem;
    logic               w_div_done;
    logic               w_div_start;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [2*WIDTH-1:0] w_commit;

    // ---------------- issue decode ----------------
    always_comb begin
        w_is_mul = (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
`ifdef MDU_ACCUM_EN
        w_is_mul = w_is_mul || (op == MDU_OP_MADD) || (op == MDU_OP_MADDU) ||
                   (op == MDU_OP_MSUB) || (op == MDU_OP_MSUBU);
`endif
    end

    assign w_is_div    = (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    // Division by zero is a silent no-op, so it never counts as long.
    assign w_is_long   = w_is_mul || (w_is_div && (srcb != '0));
    assign w_accept    = start && !abort && (r_state == ST_IDLE);
    assign w_div_start = w_accept && w_is_div && (srcb != '0);
    assign busy        = (r_state != ST_IDLE) || (start && w_is_long && !abort);

    // Both engines work on magnitudes; signs are reapplied in FIX.
    assign w_sa    = is_signed_op(op) && srca[WIDTH-1];
    assign w_sb    = is_signed_op(op) && srcb[WIDTH-1];
    assign w_mag_a = w_sa ? -srca : srca;
    assign w_mag_b = w_sb ? -srcb : srcb;

    // ---------------- multiplier step ----------------
    // r_mcand is pre-shifted each cycle, so partial product gi only needs a
    // further shift by gi within the current group of MUL_STEP bits.
    generate
        for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
            assign w_pp[gi] = r_mplier[gi] ? (r_mcand << gi) : '0;
        end
    endgenerate

    always_comb begin
        w_step_sum = r_acc;
        for (int j = 0; j < MUL_STEP; j++) begin
            w_step_sum = w_step_sum + w_pp[j];
        end
    end

    // ---------------- divider ----------------
    mdu_div_core #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .i_start    (w_div_start),
        .i_abort    (abort),
        .i_dividend (w_mag_a),
        .i_divisor  (w_mag_b),
        .o_quo      (w_div_quo),
        .o_rem      (w_div_rem),
        .o_done     (w_div_done)
    );

    // ---------------- sign fix-up and commit value ----------------
    // r_neg_res: product/quotient negative (operand signs differ).
    // r_neg_rem: remainder follows the dividend sign.
    assign w_prod    = r_neg_res ? -r_acc : r_acc;
    assign w_quo_fix = r_neg_res ? -w_div_quo : w_div_quo;
    assign w_rem_fix = r_neg_rem ? -w_div_rem : w_div_rem;

    always_comb begin
        w_commit = {r_hi, r_lo};
        case (r_op)
            MDU_OP_MULT, MDU_OP_MULTU: w_commit = w_prod;
            MDU_OP_DIV, MDU_OP_DIVU:   w_commit = {w_rem_fix, w_quo_fix};
`ifdef MDU_ACCUM_EN
            MDU_OP_MADD, MDU_OP_MADDU: w_commit = {r_hi, r_lo} + w_prod;
            MDU_OP_MSUB, MDU_OP_MSUBU: w_commit = {r_hi, r_lo} - w_prod;
`endif
            default:                   w_commit = {r_hi, r_lo};
        endcase
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_long) begin
                    w_state_next = w_is_mul ? ST_MUL : ST_DIV;
                end
            end
            ST_MUL: begin
                if (r_cnt == MCW'(STEPS - 1)) begin
                    w_state_next = ST_FIX;
                end
            end
            ST_DIV: begin
                if (w_div_done) begin
                    w_state_next = ST_FIX;
                end
            end
            ST_FIX:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        // Abort flushes any in-flight op, including the commit cycle.
        if (abort && (r_state != ST_IDLE)) begin
            w_state_next = ST_IDLE;
        end
    end

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == ST_FIX) && !abort;

            if (w_accept) begin
                if (op == MDU_OP_MTHI) begin
                    r_hi <= srca;
                end else if (op == MDU_OP_MTLO) begin
                    r_lo <= srca;
                end else if (w_is_long) begin
                    r_op      <= op;
                    r_neg_res <= w_sa ^ w_sb;
                    r_neg_rem <= w_sa;
                    r_mcand   <= {{WIDTH{1'b0}}, w_mag_a};
                    r_mplier  <= w_mag_b;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                end
            end

            if ((r_state == ST_MUL) && !abort) begin
                r_acc    <= w_step_sum;
                r_mcand  <= r_mcand << MUL_STEP;
                r_mplier <= r_mplier >> MUL_STEP;
                r_cnt    <= r_cnt + 1'b1;
            end

            if ((r_state == ST_FIX) && !abort) begin
                {r_hi, r_lo} <= w_commit;
            end
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign done = r_done;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq (WIDTH=32, MUL_STEP=4).
// Expected HI/LO values come from a behavioural model and are queued when a
// multi-cycle op is issued; the done monitor pops and compares them.
// Accumulate ops are expected to work only when MDU_ACCUM_EN is defined.
module tb_mdu_seq;
    import mdu_pkg::*;

    localparam int W       = 32;
    localparam int LAT_MUL = 9;
    localparam int LAT_DIV = 33;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    op;
    logic [W-1:0]  srca;
    logic [W-1:0]  srcb;
    logic          abort;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    mdu_seq #(
        .WIDTH    (W),
        .MUL_STEP (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .abort (abort),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    typedef struct {
        string       tag;
        logic [63:0] hilo;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    int          edge_cnt = 0;
    exp_t        sb_q[$];
    exp_t        sb_e;
    logic [63:0] model_hilo = 64'h0;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check({sb_e.tag, "_hilo"}, {hi, lo}, sb_e.hilo);
            end
        end
    end

    function automatic logic is_accum(input logic [3:0] o);
`ifdef MDU_ACCUM_EN
        return (o == MDU_OP_MADD) || (o == MDU_OP_MADDU) ||
               (o == MDU_OP_MSUB) || (o == MDU_OP_MSUBU);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic is_long_op(input logic [3:0] o, input logic [31:0] b);
        return (o == MDU_OP_MULT) || (o == MDU_OP_MULTU) || is_accum(o) ||
               (((o == MDU_OP_DIV) || (o == MDU_OP_DIVU)) && (b != 0));
    endfunction

    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint          sa;
        longint          sb;
        longint          sq;
        longint          sr;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        up = {32'h0, a} * {32'h0, b};
        case (o)
            MDU_OP_MULT:  return 64'(sa * sb);
            MDU_OP_MULTU: return up;
            MDU_OP_DIV: begin
                if (b == 0) return hl;
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            MDU_OP_DIVU: begin
                if (b == 0) return hl;
                return {a % b, a / b};
            end
            MDU_OP_MTHI:  return {a, hl[31:0]};
            MDU_OP_MTLO:  return {hl[63:32], a};
            MDU_OP_MADD:  return is_accum(o) ? hl + 64'(sa * sb) : hl;
            MDU_OP_MADDU: return is_accum(o) ? hl + up : hl;
            MDU_OP_MSUB:  return is_accum(o) ? hl - 64'(sa * sb) : hl;
            MDU_OP_MSUBU: return is_accum(o) ? hl - up : hl;
            default:      return hl;
        endcase
    endfunction

    // Issue one op, scramble the operand inputs after acceptance, and wait
    // (bounded) for the result.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic        long_op;
        logic [63:0] exp;
        int          e0;
        int          lat;
        bit          seen;
        long_op = is_long_op(o, b);
        exp     = model(o, a, b, model_hilo);
        lat     = ((o == MDU_OP_DIV) || (o == MDU_OP_DIVU)) ? LAT_DIV : LAT_MUL;
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = b; abort = 1'b0;
        #1 check({tag, "_busy_issue"}, 64'(busy), 64'(long_op));
        if (long_op) sb_q.push_back('{tag, exp});
        @(posedge clk);
        #1;
        e0    = edge_cnt;
        start = 1'b0;
        op    = 4'($urandom);
        srca  = $urandom;
        srcb  = $urandom;
        model_hilo = exp;
        if (long_op) begin
            seen = 0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                if (done === 1'b1) seen = 1;
            end
            if (!seen) begin
                check({tag, "_timeout"}, 64'd0, 64'd1);
            end else begin
                check({tag, "_latency"}, 64'(edge_cnt - e0), 64'(lat));
                check({tag, "_busy_done"}, 64'(busy), 64'd0);
                @(negedge clk);
                check({tag, "_done_pulse"}, 64'(done), 64'd0);
            end
        end else begin
            @(negedge clk);
            check({tag, "_hilo"}, {hi, lo}, exp);
            check({tag, "_busy"}, 64'(busy), 64'd0);
        end
        $display("txn %s op=%0d a=%08h b=%08h -> hi=%08h lo=%08h", tag, o, a, b, hi, lo);
    endtask

    // start together with abort must leave the unit untouched.
    task automatic issue_aborted(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input string tag);
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = b; abort = 1'b1;
        #1 check({tag, "_busy"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        check({tag, "_hilo"}, {hi, lo}, model_hilo);
        @(negedge clk);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        $display("txn %s op=%0d a=%08h b=%08h with abort -> hi=%08h lo=%08h", tag, o, a, b, hi, lo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1; start = 1'b0; abort = 1'b0; op = '0; srca = '0; srcb = '0;
        repeat (3) @(negedge clk);
        check("reset_hilo", {hi, lo}, 64'h0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        reset = 1'b0;

        // Multiply, signed and unsigned, including extreme operands.
        run_op(MDU_OP_MULT,  32'hFFFF_FFFD, 32'd5,        "mult_neg3x5");
        run_op(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(MDU_OP_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minmin");

        // Divide, signs, overflow wrap.
        run_op(MDU_OP_DIVU, 32'd7,        32'd2,         "divu_7_2");
        run_op(MDU_OP_DIV,  32'hFFFF_FFF9, 32'd2,        "div_m7_2");
        run_op(MDU_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(MDU_OP_DIV,  32'd100,      32'hFFFF_FFF9, "div_100_m7");
        run_op(MDU_OP_DIVU, 32'hFFFF_FFFF, 32'd1,        "divu_max_1");

        // MTHI then MTLO on consecutive edges: neither raises busy.
        @(negedge clk);
        start = 1'b1; op = MDU_OP_MTHI; srca = 32'h1234_5678;
        #1 check("mthi_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 op = MDU_OP_MTLO; srca = 32'h9;
        check("mtlo_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 start = 1'b0;
        model_hilo = 64'h1234_5678_0000_0009;
        @(negedge clk);
        check("mthi_mtlo_hilo", {hi, lo}, model_hilo);
        check("mthi_mtlo_done", 64'(done), 64'd0);
        $display("txn mthi_mtlo -> hi=%08h lo=%08h", hi, lo);

        // Accumulate ops (ignored unless built in).
        run_op(MDU_OP_MADDU, 32'hFFFF_FFFF, 32'd2,  "maddu");
        run_op(MDU_OP_MSUB,  32'hFFFF_FFFD, 32'd5,  "msub");
        run_op(MDU_OP_MADD,  32'h8000_0000, 32'd3,  "madd");

        // Divide by zero is a no-op.
        run_op(MDU_OP_MTHI, 32'hAA, 32'd0, "set_hi_aa");
        run_op(MDU_OP_MTLO, 32'hAA, 32'd0, "set_lo_aa");
        run_op(MDU_OP_DIV,  32'd100, 32'd0, "div_by_0");
        run_op(4'hF, 32'd1, 32'd1, "undef_op");

        // Abort a divide partway, then multiply immediately after.
        @(negedge clk);
        start = 1'b1; op = MDU_OP_DIV; srca = 32'd1000; srcb = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, model_hilo);
        run_op(MDU_OP_MULT, 32'd3, 32'd4, "mult_after_abort");

        // Reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1; op = MDU_OP_MULT; srca = 32'd7; srcb = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_hilo = 64'h0;
        @(negedge clk);
        check("midreset_hilo", {hi, lo}, 64'h0);
        check("midreset_busy", 64'(busy), 64'd0);
        repeat (12) @(negedge clk);
        $display("txn midreset -> hi=%08h lo=%08h", hi, lo);

        // start coinciding with abort.
        run_op(MDU_OP_MTLO, 32'h5555, 32'd0, "set_lo_5555");
        issue_aborted(MDU_OP_MTHI, 32'hDEAD_BEEF, 32'd0, "mthi_abort");
        issue_aborted(MDU_OP_MULT, 32'd6, 32'd7,         "mult_abort");

        // Random multiply/divide traffic.
        for (int k = 0; k < 10; k++) begin
            case ($urandom_range(0, 3))
                0:       rop = MDU_OP_MULT;
                1:       rop = MDU_OP_MULTU;
                2:       rop = MDU_OP_DIV;
                default: rop = MDU_OP_DIVU;
            endcase
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            run_op(rop, ra, rb, "rand");
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
